// File: rtl/lfsr_pkg.sv
// Shared definitions for the Galois LFSR generator/checker pair: checker state
// encoding, default tap mask and the single-step next-word function.
package lfsr_pkg;

  typedef enum logic [1:0] {
    LFSR_CHK_SEED   = 2'd0,
    LFSR_CHK_SYNC   = 2'd1,
    LFSR_CHK_LOCKED = 2'd2
  } lfsr_chk_state_e;

  localparam logic [15:0] LFSR_DEFAULT_TAPS = 16'h001D;

  // One Galois step on the low nbits of w (nbits in 2..32); upper bits are returned as zero.
  function automatic logic [31:0] lfsr_step_word(input logic [31:0] w,
                                                 input logic [31:0] taps,
                                                 input int unsigned nbits,
                                                 input logic        invert);
    logic [31:0] mask;
    logic [31:0] shifted;
    logic        fb;
    mask    = (32'd1 << nbits) - 32'd1;
    fb      = w[nbits-1] ^ invert;
    shifted = (w << 1) & mask;
    return (fb ? (shifted ^ taps) : shifted) & mask;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single-step Galois LFSR next-word logic, shared by the
// generator and both prediction paths of the checker.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               NBITS  = 16,
  parameter logic [NBITS-1:0] TAPS   = LFSR_DEFAULT_TAPS[NBITS-1:0],
  parameter bit               INVERT = 1'b0
) (
  input  logic [NBITS-1:0] word_i,
  output logic [NBITS-1:0] next_o
);

  assign next_o = NBITS'(lfsr_step_word(32'(word_i), 32'(TAPS), NBITS, INVERT));

endmodule

// File: rtl/lfsr_checker.sv
// PRBS sink: locks onto a Galois LFSR word stream and counts mismatches.
// Define LFSR_CHECK_BITERR_EN to count bit errors instead of word errors.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter                TAPS       = LFSR_DEFAULT_TAPS,
  parameter bit            INVERT     = 1'b0,
  parameter int            LOCK_COUNT = 4,
  parameter int            LOSS_COUNT = 4,
  parameter int            ERR_WIDTH  = 16,
  localparam int           NBITS      = $bits(TAPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [NBITS-1:0]     in_data,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_WIDTH-1:0] err_count
);

  // state  | meaning
  // SEED   | no prediction held
  // SYNC   | verifying a seed, counting consecutive correct predictions
  // LOCKED | tracking; expected free-runs on every valid word

  localparam int SUMW = ERR_WIDTH + 7;

  lfsr_chk_state_e      state_q, state_d;
  logic [NBITS-1:0]     expected_q, expected_d;
  logic [7:0]           match_cnt_q, match_cnt_d;
  logic [7:0]           miss_cnt_q, miss_cnt_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [ERR_WIDTH-1:0] err_count_q, err_count_d;

  logic [NBITS-1:0]     seed_next;
  logic [NBITS-1:0]     fly_next;
  logic                 is_lockup;
  logic                 mismatch;
  logic [6:0]           err_inc;
  logic [SUMW-1:0]      err_sum;
  logic [ERR_WIDTH-1:0] err_sat;

  lfsr_step #(.NBITS(NBITS), .TAPS(TAPS), .INVERT(INVERT)) u_step_seed (
    .word_i (in_data),
    .next_o (seed_next)
  );

  lfsr_step #(.NBITS(NBITS), .TAPS(TAPS), .INVERT(INVERT)) u_step_fly (
    .word_i (expected_q),
    .next_o (fly_next)
  );

  assign is_lockup = !INVERT && (in_data == '0);
  assign mismatch  = (in_data != expected_q);

`ifdef LFSR_CHECK_BITERR_EN
  assign err_inc = 7'($countones(in_data ^ expected_q));
`else
  assign err_inc = 7'd1;
`endif

  assign err_sum = SUMW'(err_count_q) + SUMW'(err_inc);
  assign err_sat = (err_sum > SUMW'({ERR_WIDTH{1'b1}})) ? {ERR_WIDTH{1'b1}}
                                                        : err_sum[ERR_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LFSR_CHK_SEED;
      expected_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;

    if (in_valid) begin
      case (state_q)
        LFSR_CHK_SEED: begin
          if (!is_lockup) begin
            expected_d  = seed_next;
            match_cnt_d = '0;
            state_d     = LFSR_CHK_SYNC;
          end
        end
        LFSR_CHK_SYNC: begin
          if (!mismatch) begin
            match_cnt_d = match_cnt_q + 8'd1;
            expected_d  = seed_next;
            if (match_cnt_d == 8'(LOCK_COUNT)) begin
              state_d    = LFSR_CHK_LOCKED;
              miss_cnt_d = '0;
            end
          end else if (is_lockup) begin
            state_d     = LFSR_CHK_SEED;
            match_cnt_d = '0;
          end else begin
            expected_d  = seed_next;
            match_cnt_d = '0;
          end
        end
        LFSR_CHK_LOCKED: begin
          expected_d = fly_next;
          if (!mismatch) begin
            miss_cnt_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_count_d = err_sat;
            miss_cnt_d  = miss_cnt_q + 8'd1;
            // Too many misses in a row: the stream moved, resync on this word.
            if (miss_cnt_d == 8'(LOSS_COUNT)) begin
              state_d     = LFSR_CHK_SYNC;
              expected_d  = seed_next;
              match_cnt_d = '0;
            end
          end
        end
        default: state_d = LFSR_CHK_SEED;
      endcase
    end

    if (clear_err) err_count_d = '0;
  end

  assign locked    = (state_q == LFSR_CHK_LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed self-checking bench for lfsr_checker (TAPS=16'h001D, INVERT=0, ERR_WIDTH=4).
module tb_lfsr_checker;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        clear_err;
  logic        locked;
  logic        err_pulse;
  logic [3:0]  err_count;

  int checks = 0;
  int errors = 0;

`ifdef LFSR_CHECK_BITERR_EN
  localparam logic [3:0] MULTI_INC = 4'd3;
`else
  localparam logic [3:0] MULTI_INC = 4'd1;
`endif

  logic [15:0] gen;
  logic [15:0] seq_a [5] = '{16'hFFFF, 16'hFFE3, 16'hFFDB, 16'hFFAB, 16'hFF4B};
  logic [15:0] seq_b [5] = '{16'h1234, 16'h2468, 16'h48D0, 16'h91A0, 16'h235D};

  lfsr_checker #(
    .TAPS       (16'h001D),
    .INVERT     (1'b0),
    .LOCK_COUNT (4),
    .LOSS_COUNT (4),
    .ERR_WIDTH  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear_err (clear_err),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] tb_step(input logic [15:0] w);
    return w[15] ? ({w[14:0], 1'b0} ^ 16'h001D) : {w[14:0], 1'b0};
  endfunction

  task automatic send_word(input logic [15:0] w, input logic clr);
    in_valid  = 1'b1;
    in_data   = w;
    clear_err = clr;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic send_good();
    send_word(gen, 1'b0);
    gen = tb_step(gen);
  endtask

  task automatic send_bad(input logic [15:0] mask, input logic clr);
    send_word(gen ^ mask, clr);
    gen = tb_step(gen);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_values: locked=%b err_pulse=%b err_count=%0d expected 0/0/0", locked, err_pulse, err_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_clean_lock();
    int pulses = 0;
    for (int i = 0; i < 4; i++) begin
      send_word(seq_a[i], 1'b0);
      if (err_pulse) pulses++;
      checks++;
      if (locked !== 1'b0) begin
        errors++;
        $display("FAIL early_lock: word %0d locked=%b expected 0", i + 1, locked);
      end
    end
    send_word(seq_a[4], 1'b0);
    if (err_pulse) pulses++;
    checks++;
    if (locked !== 1'b1 || err_count !== 4'd0 || pulses != 0) begin
      errors++;
      $display("FAIL clean_lock: locked=%b err_count=%0d pulses=%0d expected 1/0/0", locked, err_count, pulses);
    end
    gen = tb_step(seq_a[4]);
    checks++;
    if (gen !== 16'hFE8B) begin
      errors++;
      $display("FAIL gen_model: next=%h expected fe8b", gen);
    end
  endtask

  task automatic test_single_bit();
    send_good();
    send_bad(16'h0001, 1'b0);
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 4'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL single_bit: err_pulse=%b err_count=%0d locked=%b expected 1/1/1", err_pulse, err_count, locked);
    end
    send_good();
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: err_pulse=%b expected 0", err_pulse);
    end
    repeat (3) send_good();
    checks++;
    if (err_count !== 4'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL after_single: err_count=%0d locked=%b expected 1/1", err_count, locked);
    end
  endtask

  task automatic test_multi_bit();
    send_bad(16'h0700, 1'b0);
    checks++;
    if (err_count !== 4'd1 + MULTI_INC || err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL multi_bit: err_count=%0d err_pulse=%b expected %0d/1", err_count, err_pulse, 4'd1 + MULTI_INC);
    end
    send_good();
    send_word(gen, 1'b1);
    gen = tb_step(gen);
    checks++;
    if (err_count !== 4'd0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL clear_plain: err_count=%0d locked=%b expected 0/1", err_count, locked);
    end
  endtask

  task automatic test_loss_relock();
    for (int i = 0; i < 3; i++) begin
      send_bad(16'h0001, 1'b0);
      checks++;
      if (locked !== 1'b1 || err_count !== 4'(i + 1)) begin
        errors++;
        $display("FAIL loss_pre: bad %0d locked=%b err_count=%0d expected 1/%0d", i + 1, locked, err_count, i + 1);
      end
    end
    send_bad(16'h0001, 1'b0);
    checks++;
    if (locked !== 1'b0 || err_count !== 4'd4 || err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL loss: locked=%b err_count=%0d err_pulse=%b expected 0/4/1", locked, err_count, err_pulse);
    end
    for (int i = 0; i < 4; i++) send_word(seq_b[i], 1'b0);
    checks++;
    if (locked !== 1'b0 || err_count !== 4'd4) begin
      errors++;
      $display("FAIL relock_early: locked=%b err_count=%0d expected 0/4", locked, err_count);
    end
    send_word(seq_b[4], 1'b0);
    checks++;
    if (locked !== 1'b1 || err_count !== 4'd4) begin
      errors++;
      $display("FAIL relock: locked=%b err_count=%0d expected 1/4", locked, err_count);
    end
    gen = tb_step(seq_b[4]);
  endtask

  task automatic test_saturation();
    send_word(gen, 1'b1);
    gen = tb_step(gen);
    for (int i = 0; i < 20; i++) begin
      send_bad(16'h0001, 1'b0);
      send_good();
      if (i == 14) begin
        checks++;
        if (err_count !== 4'd15) begin
          errors++;
          $display("FAIL sat_reach: err_count=%0d expected 15", err_count);
        end
      end
    end
    checks++;
    if (err_count !== 4'd15 || locked !== 1'b1) begin
      errors++;
      $display("FAIL saturation: err_count=%0d locked=%b expected 15/1", err_count, locked);
    end
    send_bad(16'h0001, 1'b1);
    checks++;
    if (err_count !== 4'd0 || err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL clear_priority: err_count=%0d err_pulse=%b expected 0/1", err_count, err_pulse);
    end
  endtask

  task automatic test_gaps();
    idle(3);
    checks++;
    if (err_pulse !== 1'b0 || locked !== 1'b1 || err_count !== 4'd0) begin
      errors++;
      $display("FAIL gap_idle: err_pulse=%b locked=%b err_count=%0d expected 0/1/0", err_pulse, locked, err_count);
    end
    send_good();
    idle(2);
    send_good();
    idle(1);
    send_good();
    checks++;
    if (err_count !== 4'd0 || locked !== 1'b1 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL gap_stream: err_count=%0d locked=%b err_pulse=%b expected 0/1/0", err_count, locked, err_pulse);
    end
  endtask

  task automatic test_async_reset();
    send_bad(16'h0001, 1'b0);
    checks++;
    if (err_count !== 4'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: err_count=%0d locked=%b expected 1/1", err_count, locked);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (locked !== 1'b0 || err_count !== 4'd0 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: locked=%b err_count=%0d err_pulse=%b expected 0/0/0", locked, err_count, err_pulse);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_lockup();
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      send_word(16'h0000, 1'b0);
      if (err_pulse) pulses++;
    end
    checks++;
    if (locked !== 1'b0 || err_count !== 4'd0 || pulses != 0) begin
      errors++;
      $display("FAIL lockup: locked=%b err_count=%0d pulses=%0d expected 0/0/0", locked, err_count, pulses);
    end
    for (int i = 0; i < 5; i++) send_word(seq_a[i], 1'b0);
    checks++;
    if (locked !== 1'b1 || err_count !== 4'd0) begin
      errors++;
      $display("FAIL lock_after_lockup: locked=%b err_count=%0d expected 1/0", locked, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_bit();
    test_multi_bit();
    test_loss_relock();
    test_saturation();
    test_gaps();
    test_async_reset();
    test_lockup();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
